// File: rtl/dark_block_filter.sv
// Per-tile dark-mode filter: accumulates tile luma per band, classifies each tile column
// with hysteresis and applies the previous band's classification to the pixel stream.
module dark_block_filter #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned H_ACTIVE = 1920,
   parameter int unsigned BLK_W    = 20,
   parameter int unsigned BLK_H    = 10,
   parameter int unsigned TH_HI    = 160,
   parameter int unsigned TH_LO    = 96
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic [1:0]                              mode_i,
   input  logic                                    vin_hs_i,
   input  logic                                    vin_vs_i,
   input  logic                                    vin_de_i,
   input  logic [3*DATA_W-1:0]                     vin_data_i,
   output logic                                    vout_hs_o,
   output logic                                    vout_vs_o,
   output logic                                    vout_de_o,
   output logic [3*DATA_W-1:0]                     vout_data_o,
   output logic [$clog2(H_ACTIVE/BLK_W+1)-1:0]     light_cnt_o,
   output logic                                    band_done_o,
   output logic                                    overflow_o
);

   localparam int unsigned NB    = H_ACTIVE / BLK_W;
   localparam int unsigned PIX_W = 3 * DATA_W;
   localparam int unsigned SUM_W = DATA_W + $clog2(BLK_W * BLK_H);
   localparam int unsigned MW    = DATA_W + 8;
   localparam int unsigned XW    = (BLK_W > 1) ? $clog2(BLK_W) : 1;
   localparam int unsigned BW    = $clog2(NB + 1);
   localparam int unsigned LW    = (BLK_H > 1) ? $clog2(BLK_H) : 1;
   localparam int unsigned LCW   = $clog2(NB + 1);
   localparam logic [SUM_W-1:0] HI_SUM = SUM_W'(TH_HI * BLK_W * BLK_H);
   localparam logic [SUM_W-1:0] LO_SUM = SUM_W'(TH_LO * BLK_W * BLK_H);

   // pipeline stages
   logic              hs1_q, vs1_q, de1_q;
   logic [PIX_W-1:0]  data1_q;
   logic [1:0]        mode1_q;
   logic              hs2_q, vs2_q, de2_q;
   logic [PIX_W-1:0]  data2_q;
   logic [1:0]        mode2_q;
   logic [DATA_W-1:0] gray2_q;
   logic              hs3_q, vs3_q, de3_q;
   logic [PIX_W-1:0]  data3_q, data3_d;

   // position, statistics and classification
   logic [XW-1:0]     x_q, x_d;
   logic [BW-1:0]     blk_q, blk_d;
   logic [LW-1:0]     line_q, line_d;
   logic [SUM_W-1:0]  acc_q [NB];
   logic [SUM_W-1:0]  acc_d [NB];
   logic [NB-1:0]     state_q, state_d;
   logic              band_upd_q, band_upd_d;
   logic [LCW-1:0]    light_q, light_d;
   logic              band_done_q;
   logic              ovf_q, ovf_d;

   logic [MW-1:0]     wsum_c;
   logic [DATA_W-1:0] gray_c;
   logic              line_end_c;
   logic [NB-1:0]     state_sh_c;
   logic              tile_s_c;
   logic              extra_c;

   // luma of the S1 pixel, registered into S2
   always_comb begin
      wsum_c = MW'(77)  * MW'(data1_q[PIX_W-1 -: DATA_W])
             + MW'(150) * MW'(data1_q[2*DATA_W-1 -: DATA_W])
             + MW'(29)  * MW'(data1_q[DATA_W-1:0]);
      gray_c = DATA_W'(wsum_c >> 8);
   end

   // counters, accumulators and band classification
   always_comb begin
      x_d        = x_q;
      blk_d      = blk_q;
      line_d     = line_q;
      acc_d      = acc_q;
      state_d    = state_q;
      ovf_d      = ovf_q;
      band_upd_d = 1'b0;
      line_end_c = !de2_q && de3_q;
      if (vs2_q) begin
         x_d    = '0;
         blk_d  = '0;
         line_d = '0;
         for (int unsigned i = 0; i < NB; i++) acc_d[i] = '0;
      end else if (de2_q) begin
         if (blk_q < BW'(NB)) begin
            for (int unsigned i = 0; i < NB; i++)
               if (BW'(i) == blk_q) acc_d[i] = acc_q[i] + SUM_W'(gray2_q);
            if (x_q == XW'(BLK_W - 1)) begin
               x_d   = '0;
               blk_d = blk_q + BW'(1);
            end else begin
               x_d = x_q + XW'(1);
            end
         end else begin
            ovf_d = 1'b1;
         end
      end else if (line_end_c) begin
         x_d   = '0;
         blk_d = '0;
         if (line_q == LW'(BLK_H - 1)) begin
            line_d     = '0;
            band_upd_d = 1'b1;
            for (int unsigned i = 0; i < NB; i++) begin
               if (acc_q[i] > HI_SUM)      state_d[i] = 1'b1;
               else if (acc_q[i] < LO_SUM) state_d[i] = 1'b0;
               acc_d[i] = '0;
            end
         end else begin
            line_d = line_q + LW'(1);
         end
      end
   end

   // light tile count, sampled the cycle after the state vector changes
   always_comb begin
      light_d = light_q;
      if (band_upd_q) begin
         light_d = '0;
         for (int unsigned i = 0; i < NB; i++) light_d = light_d + LCW'(state_q[i]);
      end
   end

   // pixel filter for the S2 pixel; tile index is the current blk_q
   always_comb begin
      state_sh_c = state_q >> blk_q;
      tile_s_c   = state_sh_c[0];
      extra_c    = (blk_q == BW'(NB));
      data3_d    = data2_q;
      if (de2_q && !extra_c) begin
         case (mode2_q)
            2'd1:    data3_d = data2_q ^ {PIX_W{tile_s_c}};
            2'd2:    data3_d = ~data2_q;
            2'd3:    data3_d = tile_s_c ? '1 : '0;
            default: data3_d = data2_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         {hs1_q, vs1_q, de1_q, data1_q, mode1_q} <= '0;
         {hs2_q, vs2_q, de2_q, data2_q, mode2_q, gray2_q} <= '0;
         {hs3_q, vs3_q, de3_q, data3_q} <= '0;
         x_q         <= '0;
         blk_q       <= '0;
         line_q      <= '0;
         for (int unsigned i = 0; i < NB; i++) acc_q[i] <= '0;
         state_q     <= '0;
         band_upd_q  <= 1'b0;
         light_q     <= '0;
         band_done_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         {hs1_q, vs1_q, de1_q, data1_q, mode1_q} <= {vin_hs_i, vin_vs_i, vin_de_i, vin_data_i, mode_i};
         {hs2_q, vs2_q, de2_q, data2_q, mode2_q} <= {hs1_q, vs1_q, de1_q, data1_q, mode1_q};
         gray2_q     <= gray_c;
         {hs3_q, vs3_q, de3_q, data3_q} <= {hs2_q, vs2_q, de2_q, data3_d};
         x_q         <= x_d;
         blk_q       <= blk_d;
         line_q      <= line_d;
         acc_q       <= acc_d;
         state_q     <= state_d;
         band_upd_q  <= band_upd_d;
         light_q     <= light_d;
         band_done_q <= band_upd_q;
         ovf_q       <= ovf_d;
      end
   end

   assign vout_hs_o   = hs3_q;
   assign vout_vs_o   = vs3_q;
   assign vout_de_o   = de3_q;
   assign vout_data_o = data3_q;
   assign light_cnt_o = light_q;
   assign band_done_o = band_done_q;
   assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_dark_block_filter.sv
// Randomized bench for dark_block_filter with a line/band level reference model.
module tb_dark_block_filter;

   localparam int unsigned DW = 8, HA = 8, BWID = 4, BHT = 2, THH = 160, THL = 96;
   localparam int unsigned NB = HA / BWID;
   localparam int unsigned LCW = $clog2(NB + 1);

   logic clk, rst;
   logic [1:0] mode;
   logic hs, vs, de;
   logic [23:0] din;
   logic o_hs, o_vs, o_de;
   logic [23:0] o_data;
   logic [LCW-1:0] o_light;
   logic o_bd, o_ovf;

   dark_block_filter #(.DATA_W(DW), .H_ACTIVE(HA), .BLK_W(BWID), .BLK_H(BHT),
                       .TH_HI(THH), .TH_LO(THL)) dut (
      .clk_i(clk), .rst_i(rst), .mode_i(mode),
      .vin_hs_i(hs), .vin_vs_i(vs), .vin_de_i(de), .vin_data_i(din),
      .vout_hs_o(o_hs), .vout_vs_o(o_vs), .vout_de_o(o_de), .vout_data_o(o_data),
      .light_cnt_o(o_light), .band_done_o(o_bd), .overflow_o(o_ovf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic hs; logic vs; logic de; logic [23:0] d; } exp_t;
   exp_t exp_q[$];

   int checks = 0, errors = 0;
   int bd_seen = 0, bands_exp = 0;
   int m_px, m_line;
   int m_acc[NB];
   bit m_state[NB];
   bit m_ovf, m_prev_de;
   int base[NB];

   function automatic int popc();
      int c = 0;
      for (int i = 0; i < NB; i++) c += int'(m_state[i]);
      return c;
   endfunction

   function automatic int clamp8(input int v);
      return (v < 0) ? 0 : ((v > 255) ? 255 : v);
   endfunction

   task automatic model_reset();
      m_px = 0; m_line = 0; m_ovf = 0; m_prev_de = 0;
      for (int i = 0; i < NB; i++) begin m_acc[i] = 0; m_state[i] = 0; end
      exp_q.delete();
      bd_seen = 0; bands_exp = 0;
   endtask

   // one input cycle: apply, predict, then compare the output due this cycle
   task automatic drive(input logic h, input logic v, input logic d_en,
                        input logic [23:0] d, input logic [1:0] m);
      exp_t e;
      int r, g, b, tile;
      bit s, ext;
      @(negedge clk);
      hs = h; vs = v; de = d_en; din = d; mode = m;
      e.hs = h; e.vs = v; e.de = d_en; e.d = d;
      if (v) begin
         m_px = 0; m_line = 0;
         for (int i = 0; i < NB; i++) m_acc[i] = 0;
      end else if (d_en) begin
         ext = (m_px >= int'(HA));
         s = 0;
         if (!ext) begin
            tile = m_px / int'(BWID);
            r = int'(d[23:16]); g = int'(d[15:8]); b = int'(d[7:0]);
            m_acc[tile] += (77 * r + 150 * g + 29 * b) / 256;
            s = m_state[tile];
            case (m)
               2'd1: e.d = s ? ~d : d;
               2'd2: e.d = ~d;
               2'd3: e.d = s ? 24'hFFFFFF : 24'h000000;
               default: e.d = d;
            endcase
         end else begin
            m_ovf = 1;
         end
         m_px++;
      end else if (m_prev_de) begin
         m_px = 0;
         if (m_line == int'(BHT) - 1) begin
            m_line = 0;
            bands_exp++;
            for (int i = 0; i < NB; i++) begin
               if (m_acc[i] > int'(THH * BWID * BHT)) m_state[i] = 1;
               else if (m_acc[i] < int'(THL * BWID * BHT)) m_state[i] = 0;
               m_acc[i] = 0;
            end
         end else begin
            m_line++;
         end
      end
      m_prev_de = d_en;
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (o_bd === 1'b1) bd_seen++;
      if (exp_q.size() == 3) begin
         e = exp_q.pop_front();
         checks++;
         if ({o_hs, o_vs, o_de, o_data} !== {e.hs, e.vs, e.de, e.d}) begin
            errors++;
            $display("FAIL stream: got hs%b vs%b de%b %h, want hs%b vs%b de%b %h",
                     o_hs, o_vs, o_de, o_data, e.hs, e.vs, e.de, e.d);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'($urandom), 1'b0, 1'b0, 24'($urandom), 2'($urandom_range(0, 3)));
   endtask

   function automatic logic [23:0] pix(input int kind, input int x);
      int t, v;
      case (kind)
         1: return 24'hFFFFFF;
         2: return 24'h808080;
         3: return 24'h404040;
         4: return (x < int'(BWID)) ? 24'hFFFFFF : 24'h000000;
         5: return 24'h102030;
         6: begin
            t = x / int'(BWID);
            if (t >= int'(NB)) t = 0;
            v = base[t];
            return {8'(clamp8(v + $urandom_range(0, 40) - 20)),
                    8'(clamp8(v + $urandom_range(0, 40) - 20)),
                    8'(clamp8(v + $urandom_range(0, 40) - 20))};
         end
         default: return 24'($urandom);
      endcase
   endfunction

   // m < 0 picks a random mode per pixel
   task automatic send_line(input int n, input int kind, input int m);
      for (int x = 0; x < n; x++)
         drive(1'b0, 1'b0, 1'b1, pix(kind, x),
               (m < 0) ? 2'($urandom_range(0, 3)) : 2'(m));
      idle($urandom_range(1, 3));
   endtask

   task automatic start_frame();
      drive(1'b0, 1'b1, 1'b0, 24'($urandom), 2'd0);
      drive(1'b1, 1'b1, 1'b0, 24'($urandom), 2'd0);
      idle(2);
   endtask

   task automatic check_status(input string tag);
      idle(6);
      checks++;
      if (int'(o_light) !== popc()) begin
         errors++;
         $display("FAIL %s light_cnt: got %0d want %0d", tag, o_light, popc());
      end
      checks++;
      if (bd_seen !== bands_exp) begin
         errors++;
         $display("FAIL %s band_done pulses: got %0d want %0d", tag, bd_seen, bands_exp);
      end
      checks++;
      if (o_ovf !== m_ovf) begin
         errors++;
         $display("FAIL %s overflow: got %b want %b", tag, o_ovf, m_ovf);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; hs = 1'b1; vs = 1'b1; de = 1'b1; din = 24'($urandom); mode = 2'd3;
      repeat (2) begin
         @(posedge clk); #1;
         checks++;
         if ({o_hs, o_vs, o_de, o_data, o_light, o_bd, o_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b%b%b %h light %0d bd %b ovf %b want all 0",
                     o_hs, o_vs, o_de, o_data, o_light, o_bd, o_ovf);
         end
      end
      @(negedge clk);
      rst = 1'b0; vs = 1'b0; de = 1'b0;
      model_reset();
      send_line(HA, 0, 1);
      check_status("reset");
   endtask

   task automatic test_white_band();
      start_frame();
      send_line(HA, 1, -1);
      send_line(HA, 1, -1);
      check_status("white_band");
      send_line(HA, 5, 1);
      check_status("white_next");
   endtask

   task automatic test_hysteresis();
      start_frame();
      send_line(HA, 2, -1);
      send_line(HA, 2, -1);
      check_status("hyst_hold");
      send_line(HA, 3, -1);
      send_line(HA, 3, -1);
      check_status("hyst_dark");
   endtask

   task automatic test_modes();
      start_frame();
      send_line(HA, 4, 0);
      send_line(HA, 4, 0);
      send_line(HA, 0, 3);
      send_line(HA, 0, 2);
      send_line(HA, 0, 0);
      send_line(HA, 0, 1);
      check_status("modes");
   endtask

   task automatic test_midband_vs();
      start_frame();
      send_line(HA, 1, -1);
      start_frame();
      check_status("midband_vs");
      send_line(HA, 1, -1);
      send_line(HA, 1, -1);
      check_status("after_vs_band");
   endtask

   task automatic test_overflow();
      start_frame();
      send_line(HA + 2, 3, 2);
      check_status("overflow_line");
      send_line(HA, 3, 2);
      check_status("overflow_band");
   endtask

   task automatic test_random();
      int lens[5] = '{8, 8, 8, 6, 9};
      int lv[5] = '{40, 90, 128, 170, 230};
      for (int f = 0; f < 4; f++) begin
         start_frame();
         for (int bnd = 0; bnd < 2; bnd++) begin
            for (int i = 0; i < NB; i++) base[i] = lv[$urandom_range(0, 4)];
            for (int l = 0; l < int'(BHT); l++)
               send_line(lens[$urandom_range(0, 4)], ($urandom_range(0, 3) == 0) ? 0 : 6, -1);
         end
         check_status("random");
      end
   endtask

   initial begin
      rst = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0; din = '0; mode = '0;
      test_reset();
      test_white_band();
      test_hysteresis();
      test_modes();
      test_midband_vs();
      test_overflow();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
